// File: rtl/inc_pulse_gen.sv
// inc_pulse_gen: synchronizes and debounces a push-button into one-cycle inc pulses with optional auto-repeat
module inc_pulse_gen #(
   parameter int DB_CYCLES     = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 8,
   parameter bit REPEAT_EN     = 1'b1,
   parameter int TW            = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic inc,
   output logic pressed
);
   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
   localparam logic [TW-1:0] DB_L   = TW'(DB_CYCLES);
   localparam logic [TW-1:0] HOLD_L = TW'(HOLD_CYCLES);
   localparam logic [TW-1:0] REP_L  = TW'(REPEAT_CYCLES);
   state_t state, state_n;
   logic s1, btn_s, rep, rep_n, inc_n, pressed_n, db_hit, rpt_hit;
   logic [TW-1:0] db, db_n, db_inc, rpt, rpt_n, rpt_inc;
   assign db_inc  = (db == '1) ? db : db + 1'b1;
   assign rpt_inc = (rpt == '1) ? rpt : rpt + 1'b1;
   assign db_hit  = db_inc >= DB_L;
   // first repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES; !inc keeps pulses from touching
   assign rpt_hit = REPEAT_EN && !inc && (rpt >= (rep ? REP_L : HOLD_L) - 1'b1);
   // two-flop synchronizer for the asynchronous button
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) {btn_s, s1} <= 2'b00;
      else {btn_s, s1} <= {s1, btn};
   // debounce / repeat next-state logic; db is always 0 outside the two debounce states
   always_comb begin
      state_n = state;
      db_n    = db;
      rpt_n   = rpt;
      rep_n   = rep;
      inc_n   = 1'b0;
      case (state)
         IDLE, PRESS_DB: begin
            if (!btn_s) begin
               state_n = IDLE;
               db_n    = '0;
            end else if (db_hit) begin
               state_n = HELD;
               db_n    = '0;
               rpt_n   = '0;
               rep_n   = 1'b0;
               inc_n   = 1'b1;
            end else begin
               state_n = PRESS_DB;
               db_n    = db_inc;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_n = db_hit ? IDLE : REL_DB;
               db_n    = db_hit ? '0 : db_inc;
               rpt_n   = '0;
               rep_n   = 1'b0;
            end else if (rpt_hit) begin
               rpt_n = '0;
               rep_n = 1'b1;
               inc_n = 1'b1;
            end else begin
               rpt_n = rpt_inc;
            end
         end
         REL_DB: begin
            if (btn_s) begin
               state_n = HELD;
               db_n    = '0;
               rpt_n   = '0;
               rep_n   = 1'b0;
            end else begin
               state_n = db_hit ? IDLE : REL_DB;
               db_n    = db_hit ? '0 : db_inc;
            end
         end
         default: begin
            state_n = IDLE;
            db_n    = '0;
            rpt_n   = '0;
            rep_n   = 1'b0;
         end
      endcase
      pressed_n = (state_n == HELD) || (state_n == REL_DB);
   end
   // state, timers and registered outputs
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state   <= IDLE;
         db      <= '0;
         rpt     <= '0;
         rep     <= 1'b0;
         inc     <= 1'b0;
         pressed <= 1'b0;
      end else begin
         state   <= state_n;
         db      <= db_n;
         rpt     <= rpt_n;
         rep     <= rep_n;
         inc     <= inc_n;
         pressed <= pressed_n;
      end
endmodule

// File: tb/tb_inc_pulse_gen.sv
// tb_inc_pulse_gen: directed table-driven check of inc_pulse_gen with and without auto-repeat
module tb_inc_pulse_gen;
   logic clk, reset_n, btn;
   logic inc, pressed, inc_nr, pressed_nr;
   logic [1:0] ctr;
   int checks = 0;
   int fails = 0;
   typedef struct {
      string       name;
      int          len;
      logic [63:0] btn;
      logic [63:0] inc;
      logic [63:0] inc_nr;
      logic [63:0] pr;
   } vec_t;
   vec_t tbl[4];
   inc_pulse_gen u_dut (.clk(clk), .reset_n(reset_n), .btn(btn), .inc(inc), .pressed(pressed));
   inc_pulse_gen #(.REPEAT_EN(1'b0)) u_nr (.clk(clk), .reset_n(reset_n), .btn(btn), .inc(inc_nr), .pressed(pressed_nr));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // downstream modulo-3 counter model fed by inc
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ctr <= 2'd0;
      else if (inc) ctr <= (ctr == 2'd2) ? 2'd0 : ctr + 2'd1;
   function automatic logic [63:0] rng(int lo, int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction
   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   task automatic chk_all(string name, logic ei, logic eni, logic ep);
      chk({name, " inc"}, {7'd0, inc}, {7'd0, ei});
      chk({name, " inc_norep"}, {7'd0, inc_nr}, {7'd0, eni});
      chk({name, " pressed"}, {7'd0, pressed}, {7'd0, ep});
      chk({name, " pressed_norep"}, {7'd0, pressed_nr}, {7'd0, ep});
   endtask
   task automatic do_reset();
      btn = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask
   initial begin
      tbl[0] = '{"clean", 40, rng(0, 11), rng(5, 5), rng(5, 5), rng(5, 16)};
      tbl[1] = '{"bounce", 30, rng(0, 2) | rng(4, 5) | rng(7, 7) | rng(9, 63),
                 rng(14, 14), rng(14, 14), rng(14, 29)};
      tbl[2] = '{"repeat", 64, rng(0, 50),
                 rng(5, 5) | rng(21, 21) | rng(29, 29) | rng(37, 37) | rng(45, 45),
                 rng(5, 5), rng(5, 55)};
      tbl[3] = '{"glitch", 64, rng(0, 9) | rng(12, 63),
                 rng(5, 5) | rng(30, 30) | rng(38, 38) | rng(46, 46) | rng(54, 54) | rng(62, 62),
                 rng(5, 5), rng(5, 63)};
      reset_n = 1'b0;
      btn = 1'b0;
      for (int k = 0; k < 8; k++) begin
         btn = k[0];
         @(negedge clk);
         chk_all($sformatf("in_reset c%0d", k), 1'b0, 1'b0, 1'b0);
      end
      btn = 1'b0;
      reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk_all($sformatf("idle c%0d", k), 1'b0, 1'b0, 1'b0);
      end
      for (int t = 0; t < 4; t++) begin
         do_reset();
         for (int k = 0; k < tbl[t].len; k++) begin
            btn = tbl[t].btn[k];
            @(negedge clk);
            chk_all($sformatf("%s e%0d", tbl[t].name, k), tbl[t].inc[k], tbl[t].inc_nr[k], tbl[t].pr[k]);
         end
      end
      do_reset();
      for (int k = 0; k < 12; k++) begin
         btn = 1'b1;
         @(negedge clk);
      end
      chk("midhold pressed before reset", {7'd0, pressed}, 8'd1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1 chk_all("midhold during reset", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk_all($sformatf("midhold post e%0d", k), k == 5, k == 5, k >= 5);
      end
      do_reset();
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 20; k++) begin
            btn = (k < 8);
            @(negedge clk);
         end
         chk($sformatf("counter after press %0d", p), {6'd0, ctr}, (p == 2) ? 8'd0 : ((p == 1) ? 8'd2 : 8'd1));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
